// File: rtl/uart_word_tx.sv
// Serializes a 32-bit word as four 8N1 bytes on the Tx line, paced by the baud tick,
// with a one-deep pending slot so a result arriving mid-frame is held rather than lost.
module uart_word_tx #(
  parameter int unsigned MSB_BYTE_FIRST = 0
) (
  input  logic        clk_50m,
  input  logic        rstn,
  input  logic        clken,
  input  logic [31:0] data_in,
  input  logic        wr_en,
  output logic        Tx,
  output logic        Tx_busy,
  output logic        pending_full,
  output logic        done,
  output logic        overrun,
  output logic [1:0]  fsm_state
);

  // Handshake: wr_en is a one-cycle strobe with no ready; a write is always taken,
  // either into the shift word, into the pending slot, or dropped (setting overrun).

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_n;
  logic [31:0] shift_q, shift_n;
  logic [31:0] pend_q, pend_n;
  logic        pend_valid_q, pend_valid_n;
  logic [1:0]  byte_q, byte_n;
  logic [2:0]  bit_q, bit_n;
  logic        tx_q, tx_n;
  logic        done_q, done_n;
  logic        overrun_q, overrun_n;
  logic [1:0]  byte_sel;
  logic        cur_bit;
  logic        consume;

  always_ff @(posedge clk_50m) begin
    if (!rstn) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      byte_q       <= '0;
      bit_q        <= '0;
      tx_q         <= 1'b1;
      done_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_n;
      shift_q      <= shift_n;
      pend_q       <= pend_n;
      pend_valid_q <= pend_valid_n;
      byte_q       <= byte_n;
      bit_q        <= bit_n;
      tx_q         <= tx_n;
      done_q       <= done_n;
      overrun_q    <= overrun_n;
    end
  end

  always_comb begin
    state_n      = state_q;
    shift_n      = shift_q;
    pend_n       = pend_q;
    pend_valid_n = pend_valid_q;
    byte_n       = byte_q;
    bit_n        = bit_q;
    tx_n         = tx_q;
    done_n       = 1'b0;
    overrun_n    = overrun_q;
    consume      = 1'b0;
    byte_sel     = (MSB_BYTE_FIRST != 0) ? ~byte_q : byte_q;
    cur_bit      = shift_q[{byte_sel, bit_q}];

    case (state_q)
      IDLE: begin
        // A word parked by a write on the last stop edge goes out as the start bit
        // on the very next tick, so this path drives the start bit itself.
        if (pend_valid_q) begin
          if (clken) begin
            shift_n = pend_q;
            consume = 1'b1;
            byte_n  = '0;
            bit_n   = '0;
            tx_n    = 1'b0;
            state_n = DATA;
          end
        end else if (wr_en) begin
          shift_n = data_in;
          byte_n  = '0;
          state_n = START;
        end
      end
      START: begin
        if (clken) begin
          tx_n    = 1'b0;
          bit_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (clken) begin
          tx_n  = cur_bit;
          bit_n = bit_q + 3'd1;
          if (bit_q == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        if (clken) begin
          tx_n = 1'b1;
          if (byte_q != 2'd3) begin
            byte_n  = byte_q + 2'd1;
            state_n = START;
          end else begin
            done_n = 1'b1;
            byte_n = '0;
            if (pend_valid_q) begin
              shift_n = pend_q;
              consume = 1'b1;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (consume) pend_valid_n = 1'b0;

    // A slot freed on this same edge is reusable, so a coincident write is not dropped.
    if (wr_en && !(state_q == IDLE && !pend_valid_q)) begin
      if (!pend_valid_q || consume) begin
        pend_n       = data_in;
        pend_valid_n = 1'b1;
      end else begin
        overrun_n = 1'b1;
      end
    end
  end

  assign Tx           = tx_q;
  assign Tx_busy      = (state_q != IDLE) || pend_valid_q;
  assign pending_full = pend_valid_q;
  assign done         = done_q;
  assign overrun      = overrun_q;
  assign fsm_state    = state_q;

endmodule
